// File: rtl/invader_march.sv
// invader_march: marches the invader formation origin right/left across the
// playfield, descending one row at each edge, until it lands or is wiped out.
// Optional feature: define INVADER_SPEEDUP_EN to make the step period shrink
// as alive_cnt drops; otherwise the step period is fixed at BASE_PERIOD.
module invader_march #(
    parameter int unsigned POS_W          = 10,
    parameter int unsigned X_STEP         = 4,
    parameter int unsigned Y_STEP         = 32,
    parameter int unsigned X_INIT         = 0,
    parameter int unsigned Y_INIT         = 0,
    parameter int unsigned X_MAX          = 400,
    parameter int unsigned X_MIN          = 0,
    parameter int unsigned Y_LAND         = 576,
    parameter int unsigned ALIVE_W        = 6,
    parameter int unsigned BASE_PERIOD    = 4333333,
    parameter int unsigned MIN_PERIOD     = 1083333,
    parameter int unsigned PER_INV_PERIOD = 59090
) (
    input  logic               clk65MHz,
    input  logic               rst_n,
    input  logic               game_start,
    input  logic               pause,
    input  logic [ALIVE_W-1:0] alive_cnt,
    output logic [POS_W-1:0]   xpos,
    output logic [POS_W-1:0]   ypos,
    output logic               dir_left,
    output logic               step,
    output logic               landed
);

    // Position math carries one extra bit so edge tests cannot wrap.
    localparam int unsigned EXT_W  = POS_W + 1;
    // The timer never needs to exceed BASE_PERIOD-1.
    localparam int unsigned TMR_W  = $clog2(BASE_PERIOD + 1);
    localparam int unsigned PER_W  = 32;
    localparam int unsigned CNT_W  = PER_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RIGHT,
        ST_LEFT,
        ST_DOWN,
        ST_HALT
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;

    logic [PER_W-1:0]   period_c;
    logic [CNT_W-1:0]   cnt_next_c;
    logic               tick_c;
    logic [EXT_W-1:0]   x_right_c;
    logic [EXT_W-1:0]   y_down_c;
    logic               edge_right_c;
    logic               edge_left_c;
    logic               land_c;

`ifdef INVADER_SPEEDUP_EN
    localparam int unsigned CALC_W = 64;
    logic [CALC_W-1:0]  raw_period_c;

    // Fewer invaders -> shorter period, capped at the base period.
    always_comb begin
        raw_period_c = CALC_W'(MIN_PERIOD) + CALC_W'(alive_cnt) * CALC_W'(PER_INV_PERIOD);
        period_c     = (raw_period_c > CALC_W'(BASE_PERIOD)) ? PER_W'(BASE_PERIOD)
                                                              : raw_period_c[PER_W-1:0];
    end
`else
    // Fixed march speed; alive_cnt only matters for the wipe-out halt.
    always_comb begin
        period_c = PER_W'(BASE_PERIOD);
    end
`endif

    // Tick when the count has reached period-1; >= covers a period that shrank
    // below the running count, so the tick happens on the next live cycle.
    always_comb begin
        cnt_next_c = CNT_W'(timer) + CNT_W'(1);
        tick_c     = (cnt_next_c >= CNT_W'(period_c));
    end

    // Edge and landing decisions in the widened domain.
    always_comb begin
        x_right_c    = {1'b0, xpos} + EXT_W'(X_STEP);
        y_down_c     = {1'b0, ypos} + EXT_W'(Y_STEP);
        edge_right_c = (x_right_c > EXT_W'(X_MAX));
        edge_left_c  = ({1'b0, xpos} < (EXT_W'(X_MIN) + EXT_W'(X_STEP)));
        land_c       = (y_down_c >= EXT_W'(Y_LAND));
    end

    // March state machine with registered position, direction and flags.
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            xpos     <= POS_W'(X_INIT);
            ypos     <= POS_W'(Y_INIT);
            dir_left <= 1'b0;
            step     <= 1'b0;
            landed   <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (game_start) begin
                        state    <= ST_RIGHT;
                        timer    <= '0;
                        xpos     <= POS_W'(X_INIT);
                        ypos     <= POS_W'(Y_INIT);
                        dir_left <= 1'b0;
                        landed   <= 1'b0;
                    end
                end
                default: begin
                    if (pause) begin
                        // Everything frozen while paused.
                    end else if (alive_cnt == '0) begin
                        state <= ST_HALT;
                        timer <= '0;
                    end else if (tick_c) begin
                        timer <= '0;
                        step  <= 1'b1;
                        case (state)
                            ST_RIGHT: begin
                                if (edge_right_c) begin
                                    state    <= ST_DOWN;
                                    dir_left <= 1'b1;
                                end else begin
                                    xpos <= x_right_c[POS_W-1:0];
                                end
                            end
                            ST_LEFT: begin
                                if (edge_left_c) begin
                                    state    <= ST_DOWN;
                                    dir_left <= 1'b0;
                                end else begin
                                    xpos <= xpos - POS_W'(X_STEP);
                                end
                            end
                            default: begin
                                ypos <= y_down_c[POS_W-1:0];
                                if (land_c) begin
                                    state  <= ST_HALT;
                                    landed <= 1'b1;
                                end else if (dir_left) begin
                                    state <= ST_LEFT;
                                end else begin
                                    state <= ST_RIGHT;
                                end
                            end
                        endcase
                    end else begin
                        timer <= cnt_next_c[TMR_W-1:0];
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_invader_march.sv
// tb_invader_march: scoreboard bench for invader_march. The expected march is
// generated from the movement rules as a list of step events; a monitor pops
// one entry per observed step pulse and checks position, flags and spacing.
module tb_invader_march;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned ALIVE_W = 6;
    localparam int X_STEP  = 4;
    localparam int Y_STEP  = 32;
    localparam int X_MAX   = 12;
    localparam int Y_LAND  = 64;
    localparam int BASE_P  = 4;
    localparam int MIN_P   = 2;
    localparam int PER_INV = 1;

    logic               clk65MHz;
    logic               rst_n;
    logic               game_start;
    logic               pause;
    logic [ALIVE_W-1:0] alive_cnt;
    logic [POS_W-1:0]   xpos;
    logic [POS_W-1:0]   ypos;
    logic               dir_left;
    logic               step;
    logic               landed;

    typedef struct {
        int x;
        int y;
        int dl;
        int ld;
        int gap;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t last_exp;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   steps_seen = 0;
    int   gap = 0;
    bit   pause_prev = 1'b0;
    bit   gs_prev = 1'b0;

    invader_march #(
        .POS_W(POS_W), .X_STEP(X_STEP), .Y_STEP(Y_STEP), .X_INIT(0), .Y_INIT(0),
        .X_MAX(X_MAX), .X_MIN(0), .Y_LAND(Y_LAND), .ALIVE_W(ALIVE_W),
        .BASE_PERIOD(BASE_P), .MIN_PERIOD(MIN_P), .PER_INV_PERIOD(PER_INV)
    ) dut (
        .clk65MHz(clk65MHz), .rst_n(rst_n), .game_start(game_start), .pause(pause),
        .alive_cnt(alive_cnt), .xpos(xpos), .ypos(ypos), .dir_left(dir_left),
        .step(step), .landed(landed)
    );

    initial clk65MHz = 1'b0;
    always #5 clk65MHz = ~clk65MHz;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Clocks between steps as a function of the invader count.
    function automatic int period_of(input int a);
`ifdef INVADER_SPEEDUP_EN
        int p;
        p = MIN_P + a * PER_INV;
        return (p > BASE_P) ? BASE_P : p;
`else
        return BASE_P;
`endif
    endfunction

    // Build the whole march, from origin to landing, as expected step events.
    task automatic push_march(input int a);
        int x = 0;
        int y = 0;
        int dl = 0;
        bit going_down = 1'b0;
        int per = period_of(a);
        for (int k = 0; k < 1000; k++) begin
            if (!going_down) begin
                if (dl == 0) begin
                    if (x + X_STEP > X_MAX) begin dl = 1; going_down = 1'b1; end
                    else x = x + X_STEP;
                end else begin
                    if (x < X_STEP) begin dl = 0; going_down = 1'b1; end
                    else x = x - X_STEP;
                end
                sb_q.push_back('{x: x, y: y, dl: dl, ld: 0, gap: per});
            end else begin
                y = y + Y_STEP;
                going_down = 1'b0;
                sb_q.push_back('{x: x, y: y, dl: dl, ld: (y >= Y_LAND) ? 1 : 0, gap: per});
                if (y >= Y_LAND) break;
            end
        end
    endtask

    // Monitor: counts live clock edges since the last step/start, checks each step.
    always @(negedge clk65MHz) begin
        if (!rst_n) begin
            gap        = 0;
            pause_prev = pause;
            gs_prev    = 1'b0;
        end else begin
            if (gs_prev) gap = 0;
            else if (!pause_prev) gap++;
            if (step) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_step: got step at x=%0d y=%0d, required none", xpos, ypos);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("step_x", int'(xpos), mon_e.x);
                    check("step_y", int'(ypos), mon_e.y);
                    check("step_dir", int'(dir_left), mon_e.dl);
                    check("step_landed", int'(landed), mon_e.ld);
                    check("step_gap", gap, mon_e.gap);
                    last_exp = mon_e;
                end
                gap = 0;
                steps_seen++;
            end
            pause_prev = pause;
            gs_prev    = game_start;
        end
    end

    task automatic tick();
        @(posedge clk65MHz);
        #1;
    endtask

    task automatic start(input int a);
        alive_cnt  = ALIVE_W'(a);
        pause      = 1'b0;
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        check("start_x", int'(xpos), 0);
        check("start_y", int'(ypos), 0);
        check("start_dir", int'(dir_left), 0);
        check("start_landed", int'(landed), 0);
    endtask

    task automatic wait_steps(input int n);
        int target = steps_seen + n;
        for (int b = 0; b < 500 && steps_seen < target; b++) tick();
        check("wait_steps_reached", (steps_seen >= target) ? 1 : 0, 1);
    endtask

    // One full game: start, optional frozen interval, march to landing.
    task automatic run_march(input int a, input bit rnd_pause, input bit hold_test);
        push_march(a);
        start(a);
        if (hold_test) begin
            repeat (6) tick();
            pause = 1'b1;
            repeat (10) tick();
            check("pause_x", int'(xpos), X_STEP);
            check("pause_y", int'(ypos), 0);
            pause = 1'b0;
        end
        for (int b = 0; b < 3000 && sb_q.size() != 0; b++) begin
            pause = rnd_pause && ($urandom_range(0, 5) == 0);
            tick();
        end
        pause = 1'b0;
        check("drain_left", sb_q.size(), 0);
        sb_q.delete();
        repeat (20) tick();
        check("halt_landed", int'(landed), 1);
        check("halt_x", int'(xpos), last_exp.x);
        check("halt_y", int'(ypos), last_exp.y);
    endtask

    initial begin
        rst_n      = 1'b0;
        game_start = 1'b0;
        pause      = 1'b0;
        alive_cnt  = ALIVE_W'(5);
        repeat (3) tick();
        check("rst_x", int'(xpos), 0);
        check("rst_y", int'(ypos), 0);
        check("rst_dir", int'(dir_left), 0);
        check("rst_step", int'(step), 0);
        check("rst_landed", int'(landed), 0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_x", int'(xpos), 0);

        run_march(5, 1'b0, 1'b0);
        run_march(5, 1'b0, 1'b1);
        for (int r = 0; r < 4; r++) run_march(int'($urandom_range(1, 63)), 1'b1, 1'b0);

        // Wipe-out: alive_cnt drops to zero mid-march.
        push_march(2);
        start(2);
        wait_steps(2);
        alive_cnt = '0;
        tick();
        check("wipe_x", int'(xpos), last_exp.x);
        check("wipe_y", int'(ypos), last_exp.y);
        check("wipe_landed", int'(landed), 0);
        sb_q.delete();
        repeat (20) tick();
        check("wipe_hold_x", int'(xpos), last_exp.x);
        run_march(1, 1'b0, 1'b0);

        // Asynchronous reset between edges in the middle of a rightward march.
        push_march(3);
        start(3);
        wait_steps(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_x", int'(xpos), 0);
        check("arst_y", int'(ypos), 0);
        check("arst_dir", int'(dir_left), 0);
        check("arst_step", int'(step), 0);
        check("arst_landed", int'(landed), 0);
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("post_rst_idle_x", int'(xpos), 0);
        check("post_rst_idle_landed", int'(landed), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of run, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
